// File: rtl/mips_mem_pkg.sv
// Shared types and default constants for the IF/MEM memory port arbiter.
package mips_mem_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_IF   = 2'd1,
      ARB_DM   = 2'd2
   } arb_state_t;

   typedef enum logic {
      GNT_IF = 1'b0,
      GNT_DM = 1'b1
   } grant_t;

   localparam int DEF_ADDR_W  = 32;
   localparam int DEF_DATA_W  = 32;
   localparam int DEF_MEM_LAT = 2;

endpackage

// File: rtl/arb_latency_timer.sv
// Loadable down-counter that times the fixed memory latency; done while at zero.
module arb_latency_timer #(
   parameter int CNT_W = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_load_val,
   output logic             o_done
);

   logic [CNT_W-1:0] r_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (r_count != '0) begin
         r_count <= r_count - CNT_W'(1);
      end
   end

   assign o_done = (r_count == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory between the IF and MEM stages, one access at a time.
// ARB_ROUND_ROBIN_EN: alternate grants on simultaneous IF+DM requests (default: DM priority).
//
// state    | meaning
// ARB_IDLE | no access outstanding; arbitrate and grant this cycle
// ARB_IF   | fetch access in flight; ack (unless dropped) when timer expires
// ARB_DM   | data access in flight; ack when timer expires
module mem_port_arbiter
   import mips_mem_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int MEM_LAT = DEF_MEM_LAT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   input  logic              flush,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_ack,
   input  logic              dm_read,
   input  logic              dm_write,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              dm_ack,
   output logic              stall_if,
   output logic              stall_mem,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int CNT_W = $clog2(MEM_LAT + 1);
   localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LAT);

   arb_state_t        r_state;
   logic              r_mem_en;
   logic              r_mem_we;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [DATA_W-1:0] r_mem_wdata;
   logic              r_drop;
   logic              w_dm_req;
   logic              w_gnt_if;
   logic              w_gnt_dm;
   logic              w_load;
   logic              w_done;
   logic              w_if_ack;
   logic              w_dm_ack;

`ifdef ARB_ROUND_ROBIN_EN
   grant_t r_last_gnt;
`endif

   assign w_dm_req = dm_read | dm_write;

   always_comb begin
      w_gnt_dm = w_dm_req;
      w_gnt_if = if_req & ~w_dm_req;
`ifdef ARB_ROUND_ROBIN_EN
      // On a tie, serve whichever side did not win the previous grant.
      if (if_req && w_dm_req) begin
         w_gnt_dm = (r_last_gnt == GNT_IF);
         w_gnt_if = (r_last_gnt == GNT_DM);
      end
`endif
   end

   assign w_load = (r_state == ARB_IDLE) & (w_gnt_if | w_gnt_dm);

   arb_latency_timer #(.CNT_W(CNT_W)) u_timer (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_load),
      .i_load_val (LAT_LOAD),
      .o_done     (w_done)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ARB_IDLE;
         r_mem_en    <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_drop      <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
         r_last_gnt  <= GNT_IF;
`endif
      end else begin
         r_mem_en <= 1'b0;
         r_mem_we <= 1'b0;
         case (r_state)
            ARB_IDLE: begin
               r_drop <= 1'b0;
               if (w_gnt_dm) begin
                  r_state     <= ARB_DM;
                  r_mem_en    <= 1'b1;
                  r_mem_we    <= dm_write;
                  r_mem_addr  <= dm_addr;
                  r_mem_wdata <= dm_wdata;
`ifdef ARB_ROUND_ROBIN_EN
                  r_last_gnt  <= GNT_DM;
`endif
               end else if (w_gnt_if) begin
                  r_state    <= ARB_IF;
                  r_mem_en   <= 1'b1;
                  r_mem_addr <= if_addr;
                  r_drop     <= flush;
`ifdef ARB_ROUND_ROBIN_EN
                  r_last_gnt <= GNT_IF;
`endif
               end
            end
            ARB_IF: begin
               if (flush) r_drop <= 1'b1;
               if (w_done) begin
                  r_state <= ARB_IDLE;
                  r_drop  <= 1'b0;
               end
            end
            ARB_DM: begin
               if (w_done) r_state <= ARB_IDLE;
            end
            default: r_state <= ARB_IDLE;
         endcase
      end
   end

   // A flushed fetch still runs to completion; only its ack is withheld.
   assign w_if_ack = (r_state == ARB_IF) & w_done & ~r_drop & ~flush;
   assign w_dm_ack = (r_state == ARB_DM) & w_done;

   assign if_ack    = w_if_ack;
   assign dm_ack    = w_dm_ack;
   assign if_rdata  = w_if_ack ? mem_rdata : '0;
   assign dm_rdata  = w_dm_ack ? mem_rdata : '0;
   assign stall_if  = if_req & ~w_if_ack;
   assign stall_mem = w_dm_req & ~w_dm_ack;
   assign mem_en    = r_mem_en;
   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;

endmodule
